// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element table for the SRAM BIST.
// Element bit masks are padded to 8 so any elem_t index stays in range.
package sram_bist_pkg;

  localparam int MARCH_NUM_ELEMS = 6;

  typedef logic [2:0] elem_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam elem_t LAST_ELEM = elem_t'(MARCH_NUM_ELEMS - 1);

  // Bit e describes element e: 0 up(w0) 1 up(r0,w1) 2 up(r1,w0)
  // 3 down(r0,w1) 4 down(r1,w0) 5 up(r0); second op is always a write.
  localparam logic [7:0] MARCH_TWO_OPS = 8'b0001_1110;
  localparam logic [7:0] MARCH_DOWN    = 8'b0001_1000;
  localparam logic [7:0] MARCH_OP0_WE  = 8'b0000_0001;
  localparam logic [7:0] MARCH_OP0_PAT = 8'b0001_0100;
  localparam logic [7:0] MARCH_OP1_PAT = 8'b0000_1010;

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter for March elements.
// load selects direction and jumps to that direction's first address.
module sram_bist_addr_gen #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  load_down,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  first,
  output logic                  last
);

  logic down;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      down <= 1'b0;
    end else if (load) begin
      down <= load_down;
      addr <= load_down ? '1 : '0;
    end else if (step) begin
      addr <= down ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign first = down ? (addr == '1) : (addr == '0);
  assign last  = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST engine: one SRAM op per cycle, 1-cycle read compare.
// Define BIST_FAIL_LOG_EN to add first-failure capture ports.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 11,
  parameter int WMASK_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
`ifdef BIST_FAIL_LOG_EN
  ,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [2:0]             fail_elem,
  output logic [DATA_WIDTH-1:0]  fail_data
`endif
);

  state_t state;
  elem_t  elem;
  elem_t  elem_nxt;
  logic   opi;
  logic   ok;
  logic   rd_v;
  logic   rd_pat;
  logic   cmp_v;
  logic [DATA_WIDTH-1:0] exp_q;

  logic cur_we;
  logic cur_pat;
  logic op_last;
  logic run;
  logic mismatch;
  logic accept;

  logic ag_load;
  logic ag_load_down;
  logic ag_step;
  logic ag_first;
  logic ag_last;
  logic [ADDR_WIDTH-1:0] ag_addr;

  assign run      = (state == S_RUN);
  assign accept   = (state == S_IDLE) && start;
  assign elem_nxt = elem + 3'd1;
  assign cur_we   = opi | MARCH_OP0_WE[elem];
  assign cur_pat  = opi ? MARCH_OP1_PAT[elem] : MARCH_OP0_PAT[elem];
  assign op_last  = opi | ~MARCH_TWO_OPS[elem];
  assign mismatch = cmp_v && (sram_dout != exp_q);

  // Last op at the last address rolls straight into the next element.
  assign ag_load = accept ||
    (run && op_last && ag_last && elem != LAST_ELEM);
  assign ag_load_down = run & MARCH_DOWN[elem_nxt];
  assign ag_step = run && op_last && !ag_last;

  sram_bist_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ag_load),
    .load_down(ag_load_down),
    .step     (ag_step),
    .addr     (ag_addr),
    .first    (ag_first),
    .last     (ag_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      elem       <= '0;
      opi        <= 1'b0;
      ok         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      sram_we    <= 1'b0;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
      rd_v       <= 1'b0;
      rd_pat     <= 1'b0;
      cmp_v      <= 1'b0;
      exp_q      <= '0;
    end else begin
      done       <= 1'b0;
      sram_we    <= 1'b0;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
      rd_v       <= 1'b0;
      cmp_v      <= rd_v;
      exp_q      <= {DATA_WIDTH{rd_pat}};
      if (mismatch) ok <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            elem  <= '0;
            opi   <= 1'b0;
            ok    <= 1'b1;
            pass  <= 1'b0;
          end
        end
        S_RUN: begin
          sram_we    <= cur_we;
          sram_wmask <= '1;
          sram_addr  <= ag_addr;
          sram_din   <= cur_we ? {DATA_WIDTH{cur_pat}} : '0;
          rd_v       <= ~cur_we;
          rd_pat     <= cur_pat;
          if (!op_last) begin
            opi <= 1'b1;
          end else begin
            opi <= 1'b0;
            if (ag_last) begin
              if (elem == LAST_ELEM) state <= S_DRAIN;
              else elem <= elem_nxt;
            end
          end
        end
        S_DRAIN: begin
          if (!rd_v) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= ok & ~mismatch;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BIST_FAIL_LOG_EN
  logic [ADDR_WIDTH-1:0] cmp_addr;
  elem_t rd_elem;
  elem_t cmp_elem;
  logic  logged;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_elem   <= '0;
      cmp_elem  <= '0;
      cmp_addr  <= '0;
      logged    <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else begin
      rd_elem  <= elem;
      cmp_elem <= rd_elem;
      cmp_addr <= sram_addr;
      if (accept) begin
        logged    <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
        fail_data <= '0;
      end else if (mismatch && !logged) begin
        logged    <= 1'b1;
        fail_addr <= cmp_addr;
        fail_elem <= cmp_elem;
        fail_data <= sram_dout;
      end
    end
  end
`endif

endmodule
